// File: rtl/bfp_frame_normalizer.sv
// bfp_frame_normalizer
//   Block-floating-point exponent stage. Buffers one frame of FRAME exponents
//   (LANES per beat), tracks the frame maximum, then replays the frame with
//   every exponent re-biased against that maximum (zero preserved, negative
//   results clamped to zero). The maximum is exported for downstream scaling.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   block accepts an input beat (high in FILL)
//   in_exp     LANES packed exponents, lane i at [EXP_WIDTH*(i+1)-1 : EXP_WIDTH*i]
//   out_valid  output beat valid (high in DRAIN)
//   out_ready  downstream accepts the output beat
//   out_exp    normalized exponents, same lane packing as in_exp
//   out_last   high on the final beat of a frame
//   frame_max  maximum exponent of the frame being drained
//
// State table
//   FILL  | accepting input beats into the buffer, accumulating the running max
//   DRAIN | replaying buffered beats re-biased against frame_max

module bfp_frame_normalizer #(
  parameter int EXP_WIDTH = 4,
  parameter int LANES     = 8,
  parameter int FRAME     = 64,
  parameter int BIAS      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*EXP_WIDTH-1:0] in_exp,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*EXP_WIDTH-1:0] out_exp,
  output logic                       out_last,
  output logic [EXP_WIDTH-1:0]       frame_max
);

  localparam int NB = FRAME / LANES;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int DW = LANES * EXP_WIDTH;

  localparam logic [CW-1:0]      CNT_LAST = CW'(NB - 1);
  localparam logic [EXP_WIDTH:0] BIAS_X   = (EXP_WIDTH + 1)'(BIAS);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Per-lane re-bias. The extra top bit of t acts as the sign of e+BIAS-m.
  function automatic logic [EXP_WIDTH-1:0] norm_lane(
    input logic [EXP_WIDTH-1:0] e,
    input logic [EXP_WIDTH-1:0] m
  );
    logic [EXP_WIDTH:0] t;
    logic [EXP_WIDTH-1:0] r;
    t = {1'b0, e} + BIAS_X - {1'b0, m};
    if ((e == '0) || t[EXP_WIDTH]) begin
      r = '0;
    end else begin
      r = t[EXP_WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] norm_beat(
    input logic [DW-1:0]        beat,
    input logic [EXP_WIDTH-1:0] m
  );
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r[i*EXP_WIDTH +: EXP_WIDTH] = norm_lane(beat[i*EXP_WIDTH +: EXP_WIDTH], m);
    end
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [EXP_WIDTH-1:0] run_max_q, run_max_d;
  logic [EXP_WIDTH-1:0] frame_max_q, frame_max_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [DW-1:0]        out_exp_q, out_exp_d;

  logic [DW-1:0]        beat_mem_q [NB];

  logic                 in_xfer;
  logic                 out_xfer;
  logic                 wr_en;
  logic [CW-1:0]        cnt_inc;
  logic [EXP_WIDTH-1:0] beat_max;

  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    beat_max = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_exp[i*EXP_WIDTH +: EXP_WIDTH] > beat_max) begin
        beat_max = in_exp[i*EXP_WIDTH +: EXP_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    frame_max_d = frame_max_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_exp_d   = out_exp_q;
    wr_en       = 1'b0;

    unique case (state_q)
      FILL: begin
        if (in_xfer) begin
          wr_en = 1'b1;
          if (beat_max > run_max_q) begin
            run_max_d = beat_max;
          end
          if (cnt_q == CNT_LAST) begin
            // The last beat is still in flight to the buffer, but beat 0 was
            // written long ago, so the first output can be prepared now using
            // the max that already includes the last beat's lanes.
            frame_max_d = run_max_d;
            cnt_d       = '0;
            state_d     = DRAIN;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_last_d  = (CNT_LAST == '0);
            out_exp_d   = norm_beat(beat_mem_q[0], run_max_d);
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      DRAIN: begin
        if (out_xfer) begin
          if (cnt_q == CNT_LAST) begin
            run_max_d   = '0;
            cnt_d       = '0;
            state_d     = FILL;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_exp_d   = '0;
          end else begin
            // Outputs are registered, so prefetch the next beat on transfer.
            cnt_d      = cnt_inc;
            out_last_d = (cnt_inc == CNT_LAST);
            out_exp_d  = norm_beat(beat_mem_q[cnt_inc], frame_max_q);
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      run_max_q   <= '0;
      frame_max_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_exp_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      frame_max_q <= frame_max_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_exp_q   <= out_exp_d;
    end
  end

  // Frame buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      beat_mem_q[cnt_q] <= in_exp;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_exp   = out_exp_q;
  assign frame_max = frame_max_q;

endmodule

// File: tb/tb_bfp_frame_normalizer.sv
module tb_bfp_frame_normalizer;

  localparam int EW    = 4;
  localparam int LANES = 8;
  localparam int FRAME = 64;
  localparam int BIAS  = 8;
  localparam int NB    = FRAME / LANES;
  localparam int DW    = LANES * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_exp;
  logic          out_last;
  logic [EW-1:0] frame_max;

  int n_assert = 0;
  int n_fail   = 0;
  int frame_e [FRAME];

  always #5 clk = ~clk;

  bfp_frame_normalizer #(
    .EXP_WIDTH(EW),
    .LANES    (LANES),
    .FRAME    (FRAME),
    .BIAS     (BIAS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_exp  (out_exp),
    .out_last (out_last),
    .frame_max(frame_max)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_max();
    int m = 0;
    for (int j = 0; j < FRAME; j++) if (frame_e[j] > m) m = frame_e[j];
    return m;
  endfunction

  function automatic int ref_norm(input int e, input int m);
    int t;
    if (e == 0) return 0;
    t = e + BIAS - m;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic logic [31:0] ref_beat(input int b, input int m);
    logic [31:0] r = '0;
    for (int i = 0; i < LANES; i++) r[i*EW +: EW] = EW'(ref_norm(frame_e[b*LANES+i], m));
    return r;
  endfunction

  task automatic fill_frame(input int gap_pct);
    int b = 0;
    int cyc = 0;
    while (b < NB && cyc < 500) begin
      @(negedge clk);
      cyc++;
      check("fill_in_ready", 32'(in_ready), 1);
      check("fill_out_valid", 32'(out_valid), 0);
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < LANES; i++) in_exp[i*EW +: EW] = EW'(frame_e[b*LANES+i]);
        b++;
      end
    end
    check("fill_timeout", 32'(b), NB);
  endtask

  task automatic drain_frame(input int stall_pct, input int abort_at);
    int m = ref_max();
    int k = 0;
    int cyc = 0;
    bit aborted = 0;
    while (k < NB && cyc < 500 && !aborted) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      check("drain_out_valid", 32'(out_valid), 1);
      check("drain_in_ready", 32'(in_ready), 0);
      check("drain_out_exp", out_exp, ref_beat(k, m));
      check("drain_out_last", 32'(out_last), (k == NB - 1) ? 1 : 0);
      check("drain_frame_max", 32'(frame_max), m);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_last", 32'(out_last), 0);
        check("abort_out_exp", out_exp, 0);
        check("abort_frame_max", 32'(frame_max), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        aborted = 1;
      end else begin
        out_ready = ($urandom_range(0, 99) >= stall_pct);
        if (out_ready) k++;
      end
    end
    if (!aborted) begin
      check("drain_timeout", 32'(k), NB);
      @(negedge clk);
      out_ready = 1'b0;
      check("post_in_ready", 32'(in_ready), 1);
      check("post_out_valid", 32'(out_valid), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_exp = '0;

    // reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_exp", out_exp, 0);
    check("rst_frame_max", 32'(frame_max), 0);
    rst = 1'b0;

    // all fives, no stalls
    for (int j = 0; j < FRAME; j++) frame_e[j] = 5;
    fill_frame(0);
    drain_frame(0, -1);

    // 0,3,15,1 lane patterns with the 15s only in the last beat
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < LANES; i++) begin
        case (i % 4)
          0: frame_e[b*LANES+i] = 0;
          1: frame_e[b*LANES+i] = 3;
          2: frame_e[b*LANES+i] = (b == NB - 1) ? 15 : 1;
          default: frame_e[b*LANES+i] = (b == NB - 1) ? 1 : 3;
        endcase
      end
    end
    fill_frame(0);
    drain_frame(0, -1);

    // all-zero frame
    for (int j = 0; j < FRAME; j++) frame_e[j] = 0;
    fill_frame(0);
    drain_frame(0, -1);

    // boundary: max 9 with e=1 (t=0) and e=2 (t=1)
    for (int j = 0; j < FRAME; j++) frame_e[j] = $urandom_range(0, 9);
    frame_e[0] = 1;
    frame_e[1] = 2;
    frame_e[FRAME-1] = 9;
    fill_frame(0);
    drain_frame(0, -1);

    // random frames with input gaps and output stalls
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < FRAME; j++) frame_e[j] = $urandom_range(0, 15);
      fill_frame(30);
      drain_frame(50, -1);
    end

    // reset on drain beat 4, then a fresh frame with max 7
    for (int j = 0; j < FRAME; j++) frame_e[j] = $urandom_range(0, 15);
    frame_e[5] = 15;
    fill_frame(0);
    drain_frame(0, 4);
    for (int j = 0; j < FRAME; j++) frame_e[j] = $urandom_range(0, 7);
    frame_e[20] = 7;
    fill_frame(20);
    drain_frame(30, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
